dec_bin: RTL and testbench

//  Sequential BCD-to-binary converter: the inverse of the score path's binary-to-BCD unit.
//  - Accepts a 3-digit decimal value (hundreds/tens/ones, e.g. from keypad or preset entry).
//  - Returns the unsigned binary equivalent using reverse double-dabble (shift right, then

---
 rtl/dec_bin.sv | 126 ++++++++++++
 tb/tb_dec_bin.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/dec_bin.sv
// dec_bin: sequential BCD-to-binary converter (reverse double-dabble).
// Takes a captured 3-digit BCD value and produces its binary equivalent,
// one bit per clock. The latency is fixed at 11 clocks from the accepted start
// to the done pulse, including for invalid digits. A digit above 9 makes the
// result bin=0 and err=1.
module dec_bin #(
    parameter int BIN_W = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       hun,
    input  logic [3:0]       ten,
    input  logic [3:0]       one,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [BIN_W-1:0] bin
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        FINISH = 2'd2
    } state_t;

    // Number of shift steps: one per result bit (999 fits in 10 bits).
    localparam logic [3:0] LAST_STEP = 4'd9;

    state_t      state_r;
    logic [21:0] sr_r;       // {bcd[11:0], acc[9:0]}
    logic [3:0]  count_r;
    logic        bad_r;

    logic [21:0] shifted_s;
    logic [21:0] sr_next_s;
    logic        bad_in_s;

    // Reverse double-dabble correction: after a right shift, a digit >= 8
    // holds a borrowed 8 that must count as 5, so subtract 3 (4-bit wrap).
    function automatic logic [3:0] fix_digit(input logic [3:0] d);
        logic [3:0] r;
        if (d >= 4'd8) begin
            r = d - 4'd3;
        end else begin
            r = d;
        end
        return r;
    endfunction

    // A BCD digit is invalid when it encodes a value above nine.
    function automatic logic digit_bad(input logic [3:0] d);
        return (d > 4'd9);
    endfunction

    // Next shift-register value: shift right by one, then correct all three
    // digits in parallel on the post-shift value.
    always_comb begin
        shifted_s = 22'd0;
        sr_next_s = 22'd0;
        shifted_s = sr_r >> 1;
        sr_next_s = {fix_digit(shifted_s[21:18]),
                     fix_digit(shifted_s[17:14]),
                     fix_digit(shifted_s[13:10]),
                     shifted_s[9:0]};
    end

    // Flag an invalid input digit in any position at capture time.
    always_comb begin
        bad_in_s = 1'b0;
        bad_in_s = digit_bad(hun) | digit_bad(ten) | digit_bad(one);
    end

    // Control FSM with datapath and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            sr_r    <= 22'd0;
            count_r <= 4'd0;
            bad_r   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            bin     <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        sr_r    <= {hun, ten, one, 10'd0};
                        bad_r   <= bad_in_s;
                        count_r <= 4'd0;
                        busy    <= 1'b1;
                        state_r <= SHIFT;
                    end
                end
                SHIFT: begin
                    sr_r    <= sr_next_s;
                    count_r <= count_r + 4'd1;
                    if (count_r == LAST_STEP) begin
                        state_r <= FINISH;
                    end
                end
                FINISH: begin
                    // An invalid digit forces a zero result; err is held
                    // until the next done.
                    if (bad_r) begin
                        bin <= '0;
                    end else begin
                        bin <= BIN_W'(sr_r[9:0]);
                    end
                    err     <= bad_r;
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dec_bin.sv
// Self-checking bench for dec_bin: directed cases, a full valid sweep and
// random digits (including invalid ones), all checked against an arithmetic
// reference model.
module tb_dec_bin;

    logic       clk;
    logic       rst;
    logic       start;
    logic [3:0] hun;
    logic [3:0] ten;
    logic [3:0] one;
    logic       busy;
    logic       done;
    logic       err;
    logic [9:0] bin;

    int vectors;
    int miscompares;
    int cyc;

    dec_bin #(.BIN_W(10)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .hun   (hun),
        .ten   (ten),
        .one   (one),
        .busy  (busy),
        .done  (done),
        .err   (err),
        .bin   (bin)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count rising edges so that done spacing can be measured.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Reference model: the decimal value of the digits, or an error with a zero result.
    function automatic logic [10:0] ref_model(input int h, input int t, input int o);
        if (h > 9 || t > 9 || o > 9) begin
            return {1'b1, 10'd0};
        end else begin
            return {1'b0, 10'(h * 100 + t * 10 + o)};
        end
    endfunction

    // Wait (at falling edges) until done is seen or the budget runs out.
    task automatic wait_done(output int lat);
        lat = 0;
        while (done !== 1'b1 && lat < 30) begin
            @(negedge clk);
            lat++;
        end
    endtask

    // Run a single conversion and compare latency, result, err and the done pulse.
    // Inputs are scrambled while busy to show that they have no effect.
    task automatic run(input int h, input int t, input int o, input string tag,
                       input bit scramble, input bit check_busy);
        int lat;
        logic [10:0] exp_v;
        exp_v = ref_model(h, t, o);
        @(negedge clk);
        hun = 4'(h); ten = 4'(t); one = 4'(o); start = 1'b1;
        @(negedge clk);                 // E0 has sampled start
        start = 1'b0;
        lat = 0;
        while (done !== 1'b1 && lat < 30) begin
            if (check_busy) check({tag, "_busy"}, 32'(busy), 32'd1);
            if (scramble) begin
                hun = 4'($urandom); ten = 4'($urandom); one = 4'($urandom);
            end
            @(negedge clk);
            lat++;
        end
        check({tag, "_lat"}, 32'(lat), 32'd11);
        check({tag, "_bin"}, 32'(bin), 32'(exp_v[9:0]));
        check({tag, "_err"}, 32'(err), 32'(exp_v[10]));
        if (check_busy) check({tag, "_busy_end"}, 32'(busy), 32'd0);
        @(negedge clk);
        if (check_busy) check({tag, "_done_1cyc"}, 32'(done), 32'd0);
    endtask

    initial begin
        int lat;
        int t0;
        int t1;
        int ndone;
        vectors = 0;
        miscompares = 0;
        cyc = 0;
        rst = 1'b1;
        start = 1'b0;
        hun = 4'd0; ten = 4'd0; one = 4'd0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err",  32'(err),  32'd0);
        check("rst_bin",  32'(bin),  32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Directed cases
        run(0, 0, 0, "zero", 1'b0, 1'b1);
        run(9, 9, 9, "max", 1'b1, 1'b1);
        run(2, 5, 5, "v255", 1'b1, 1'b1);
        run(1, 2, 8, "v128", 1'b1, 1'b1);
        run(1, 10, 3, "bad_ten", 1'b1, 1'b1);
        check("err_held", 32'(err), 32'd1);
        run(0, 4, 2, "v42", 1'b1, 1'b1);
        run(15, 0, 0, "bad_hun", 1'b0, 1'b1);
        run(0, 0, 12, "bad_one", 1'b0, 1'b1);

        // Re-pulse start mid-conversion: ignored
        @(negedge clk);
        hun = 4'd3; ten = 4'd2; one = 4'd1; start = 1'b1;
        @(negedge clk);                 // after E0
        start = 1'b0;
        repeat (4) @(negedge clk);      // after E4
        hun = 4'd9; ten = 4'd9; one = 4'd9; start = 1'b1;
        @(negedge clk);                 // after E5
        start = 1'b0;
        wait_done(lat);
        check("repulse_lat", 32'(lat + 5), 32'd11);
        check("repulse_bin", 32'(bin), 32'd321);
        ndone = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done === 1'b1) ndone++;
        end
        check("repulse_single_done", 32'(ndone), 32'd0);

        // Held start: back-to-back conversions every 12 cycles
        hun = 4'd1; ten = 4'd2; one = 4'd3; start = 1'b1;
        @(negedge clk);
        wait_done(lat);
        t0 = cyc;
        check("held_bin0", 32'(bin), 32'd123);
        hun = 4'd8; ten = 4'd7; one = 4'd6;
        @(negedge clk);
        wait_done(lat);
        t1 = cyc;
        start = 1'b0;
        check("held_spacing", 32'(t1 - t0), 32'd12);
        check("held_bin1", 32'(bin), 32'd876);
        repeat (3) @(negedge clk);
        check("held_idle", 32'(busy), 32'd0);

        // Reset mid-conversion
        @(negedge clk);
        hun = 4'd7; ten = 4'd7; one = 4'd7; start = 1'b1;
        @(negedge clk);                 // after E0
        start = 1'b0;
        repeat (5) @(negedge clk);      // after E5
        rst = 1'b1;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_bin",  32'(bin),  32'd0);
        check("abort_err",  32'(err),  32'd0);
        @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done === 1'b1) ndone++;
        end
        check("abort_no_done", 32'(ndone), 32'd0);
        run(5, 0, 0, "after_abort", 1'b1, 1'b1);

        // Full sweep of all valid codes
        for (int v = 0; v < 1000; v++) begin
            run(v / 100, (v / 10) % 10, v % 10, "sweep", 1'b1, 1'b0);
        end

        // Random digits including invalid codes
        for (int i = 0; i < 300; i++) begin
            run(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                int'($urandom_range(0, 15)), "rand", 1'b1, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
